// File: rtl/sync_fifo_asymm_fwft.sv
// sync_fifo_asymm_fwft: single-clock first-word-fall-through FIFO whose write
// and read ports may differ in width by a power-of-two ratio R (1..16).
// Optional feature macro: SYNC_FIFO_ASYMM_FLUSH_EN adds the wr_flush input.
// wr_flush commits a partially packed word in read-wider mode.
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and full=0.
// A read is accepted when rd_en=1 and has_data=1. A strobe that is not
// accepted changes nothing. rd_data is valid whenever has_data=1, and it
// only moves after an accepted read.
module sync_fifo_asymm_fwft #(
  parameter int WR_WIDTH_BYTES = 4,
  parameter int RD_WIDTH_BYTES = 1,
  parameter int ADDR_WIDTH     = 10,
  parameter int RESERVE        = 0
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
  input  logic                        wr_flush,
`endif
  input  logic                        wr_en,
  input  logic [8*WR_WIDTH_BYTES-1:0] wr_data,
  output logic                        full,
  input  logic                        rd_en,
  output logic [8*RD_WIDTH_BYTES-1:0] rd_data,
  output logic                        empty,
  output logic                        has_data
);
  localparam int WR_W     = 8 * WR_WIDTH_BYTES;
  localparam int RD_W     = 8 * RD_WIDTH_BYTES;
  localparam int MAX_B    = (WR_WIDTH_BYTES > RD_WIDTH_BYTES) ? WR_WIDTH_BYTES : RD_WIDTH_BYTES;
  localparam int MIN_B    = (WR_WIDTH_BYTES > RD_WIDTH_BYTES) ? RD_WIDTH_BYTES : WR_WIDTH_BYTES;
  localparam int R        = MAX_B / MIN_B;
  localparam int W        = 8 * MAX_B;
  localparam bit WR_WIDER = (WR_WIDTH_BYTES > RD_WIDTH_BYTES);
  localparam bit RD_WIDER = (RD_WIDTH_BYTES > WR_WIDTH_BYTES);
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int LIMIT    = DEPTH - RESERVE;
  localparam int SW       = (R > 1) ? $clog2(R) : 1;
  localparam int CW       = ADDR_WIDTH + 1;

  if ((MAX_B % MIN_B) != 0 ||
      !(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_ratio
    $error("sync_fifo_asymm_fwft: width ratio must be a power of two from 1 to 16");
  end
  if (RESERVE < 0 || RESERVE >= DEPTH) begin : g_bad_reserve
    $error("sync_fifo_asymm_fwft: RESERVE must be in 0 .. 2**ADDR_WIDTH-1");
  end

  // Storage and pointers. A word stays in mem_q until its last slice is read.
  logic [W-1:0]          mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         remain;
  logic [SW-1:0]         rd_slice_q, rd_slice_d;
  logic [W-1:0]          head_q, head_d;
  logic                  head_valid_q, head_valid_d;

  logic                  wr_acc, rd_acc, slice_last;
  logic                  commit, pop;
  logic [W-1:0]          commit_word;

  // Full is forced high in reset so no write can slip in.
  assign full       = rst | (count_q >= CW'(LIMIT));
  assign wr_acc     = wr_en & ~full;
  assign rd_acc     = rd_en & head_valid_q;
  assign slice_last = (rd_slice_q == SW'(R - 1));
  // The word leaves storage on its last slice (or at once when read side is not narrower).
  assign pop        = rd_acc & (!WR_WIDER || slice_last);

  assign has_data   = head_valid_q;
  assign empty      = ~head_valid_q;
  assign rd_data    = head_valid_q ? head_q[int'(rd_slice_q) * RD_W +: RD_W] : '0;

`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
  logic unused_flush;
  assign unused_flush = wr_flush;
`endif

  if (RD_WIDER) begin : g_pack
    logic [W-1:0]  pack_q, pack_d;
    logic [SW-1:0] pack_cnt_q, pack_cnt_d;
    logic [W-1:0]  merged;
    logic          pack_last;
    logic          flush_eff;

    assign pack_last = (pack_cnt_q == SW'(R - 1));
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    assign flush_eff = wr_flush & ~full & (pack_cnt_q != '0);
`else
    assign flush_eff = 1'b0;
`endif
    assign commit      = (wr_acc & pack_last) | flush_eff;
    assign commit_word = wr_acc ? merged : pack_q;

    // Place the incoming slice into the pack word and compute the next pack state.
    always_comb begin
      merged = pack_q;
      merged[int'(pack_cnt_q) * WR_W +: WR_W] = wr_data;
      pack_d     = pack_q;
      pack_cnt_d = pack_cnt_q;
      if (commit) begin
        // Clearing on commit keeps unfilled upper slices zero for a later flush.
        pack_d     = '0;
        pack_cnt_d = '0;
      end else if (wr_acc) begin
        pack_d     = merged;
        pack_cnt_d = pack_cnt_q + SW'(1);
      end
    end

    // Pack register and pack count.
    always_ff @(posedge clk) begin
      if (rst) begin
        pack_q     <= '0;
        pack_cnt_q <= '0;
      end else begin
        pack_q     <= pack_d;
        pack_cnt_q <= pack_cnt_d;
      end
    end
  end else begin : g_direct
    assign commit      = wr_acc;
    assign commit_word = wr_data;
  end

  // Pointer, count, slice and FWFT head-register next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(commit);
    rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d      = count_q + CW'(commit) - CW'(pop);
    remain       = count_q - CW'(pop);
    rd_slice_d   = rd_slice_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    if (rd_acc && WR_WIDER) begin
      rd_slice_d = slice_last ? '0 : rd_slice_q + SW'(1);
    end
    if (!head_valid_q || pop) begin
      if (remain != '0) begin
        // The next word was stored on an earlier edge.
        head_d       = mem_q[rd_ptr_d];
        head_valid_d = 1'b1;
      end else if (pop && commit) begin
        // Streaming through a one-word FIFO: forward the committing word so
        // the output never shows a gap. From empty, the head instead loads
        // one edge after the commit.
        head_d       = commit_word;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_slice_q   <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_slice_q   <= rd_slice_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Storage write port. Data contents need no reset.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem_q[wr_ptr_q] <= commit_word;
    end
  end

endmodule

// File: tb/tb_sync_fifo_asymm_fwft.sv
// Bench for sync_fifo_asymm_fwft: three instances (4:1 write-wider with
// reserve, 1:4 read-wider, 1:1 equal), a vector table for the write-wider
// instance and hand-written sequences for the other two.
module tb_sync_fifo_asymm_fwft;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        a_wr_en, a_rd_en, a_full, a_empty, a_has;
  logic [31:0] a_wr_data;
  logic [7:0]  a_rd_data;

  logic        b_wr_en, b_rd_en, b_full, b_empty, b_has;
  logic [7:0]  b_wr_data;
  logic [31:0] b_rd_data;
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
  logic        b_flush;
`endif

  logic        c_wr_en, c_rd_en, c_full, c_empty, c_has;
  logic [7:0]  c_wr_data;
  logic [7:0]  c_rd_data;

  sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(4), .RD_WIDTH_BYTES(1), .ADDR_WIDTH(4), .RESERVE(2)) u_dut_a (
    .clk(clk), .rst(rst),
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    .wr_flush(1'b0),
`endif
    .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .empty(a_empty), .has_data(a_has)
  );

  sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(1), .RD_WIDTH_BYTES(4), .ADDR_WIDTH(4), .RESERVE(0)) u_dut_b (
    .clk(clk), .rst(rst),
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    .wr_flush(b_flush),
`endif
    .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .empty(b_empty), .has_data(b_has)
  );

  sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(1), .RD_WIDTH_BYTES(1), .ADDR_WIDTH(4), .RESERVE(0)) u_dut_c (
    .clk(clk), .rst(rst),
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    .wr_flush(1'b0),
`endif
    .wr_en(c_wr_en), .wr_data(c_wr_data), .full(c_full),
    .rd_en(c_rd_en), .rd_data(c_rd_data), .empty(c_empty), .has_data(c_has)
  );

  // ---------------- scoreboard / counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        exp_has;
    logic [7:0]  exp_rd;
    logic        exp_full;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(input logic we, input logic [31:0] wd, input logic re,
                                  input logic eh, input logic [7:0] er, input logic ef);
    vec_t v;
    v.wr_en = we; v.wr_data = wd; v.rd_en = re;
    v.exp_has = eh; v.exp_rd = er; v.exp_full = ef;
    vecs.push_back(v);
  endfunction

  // Word i of the fill pattern holds bytes 0x40+4i .. 0x43+4i, LSB first.
  function automatic logic [31:0] word_a(input int i);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(64 + 4*i + b);
    return w;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
    b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
    c_wr_en = 0; c_rd_en = 0; c_wr_data = '0;
`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    b_flush = 0;
`endif

    // Vector table for the 4:1 instance (ADDR_WIDTH=4, RESERVE=2 -> full at 14 words).
    add_vec(1, 32'h44332211, 0, 0, 8'h00, 0);  // commit on empty: head not yet shown
    add_vec(0, 32'h0,        0, 1, 8'h11, 0);  // one edge later
    add_vec(0, 32'h0,        1, 1, 8'h22, 0);
    add_vec(0, 32'h0,        1, 1, 8'h33, 0);
    add_vec(0, 32'h0,        1, 1, 8'h44, 0);
    add_vec(0, 32'h0,        1, 0, 8'h00, 0);  // last slice popped
    for (int i = 0; i < 14; i++)
      add_vec(1, word_a(i), 0, (i > 0), (i > 0) ? 8'h40 : 8'h00, (i == 13));
    add_vec(1, 32'hDEADBEEF, 0, 1, 8'h40, 1);  // refused while full
    for (int r = 1; r <= 56; r++)
      add_vec(0, 32'h0, 1, (r < 56), (r < 56) ? 8'(64 + r) : 8'h00, (r < 4));

    // Reset state.
    repeat (3) tick();
    check("rst a full", a_full, 1);
    check("rst b full", b_full, 1);
    check("rst c full", c_full, 1);
    check("rst a empty", a_empty, 1);
    check("rst b has_data", b_has, 0);
    check("rst a rd_data", a_rd_data, 0);
    check("rst b rd_data", b_rd_data, 0);
    check("rst c empty", c_empty, 1);
    rst = 1'b0;
    tick();
    check("post-rst a full", a_full, 0);
    check("post-rst b full", b_full, 0);
    check("post-rst c full", c_full, 0);
    check("post-rst a empty", a_empty, 1);

    // Apply the table.
    foreach (vecs[k]) begin
      a_wr_en = vecs[k].wr_en; a_wr_data = vecs[k].wr_data; a_rd_en = vecs[k].rd_en;
      tick();
      check($sformatf("vec%0d has_data", k), a_has, vecs[k].exp_has);
      check($sformatf("vec%0d empty", k), a_empty, !vecs[k].exp_has);
      check($sformatf("vec%0d rd_data", k), a_rd_data, vecs[k].exp_rd);
      check($sformatf("vec%0d full", k), a_full, vecs[k].exp_full);
    end
    a_wr_en = 0; a_rd_en = 0;

    // 1:4 packing: three slices keep it empty, the fourth commits.
    b_wr_en = 1;
    b_wr_data = 8'hA1; tick(); check("pack1 has_data", b_has, 0);
    b_wr_data = 8'hB2; tick(); check("pack2 has_data", b_has, 0);
    b_wr_data = 8'hC3; tick(); check("pack3 has_data", b_has, 0);
    b_wr_data = 8'hD4; tick(); check("pack4 edge N has_data", b_has, 0);
    b_wr_en = 0;
    tick();
    check("pack4 edge N+1 has_data", b_has, 1);
    check("pack4 rd_data", b_rd_data, 32'hD4C3B2A1);
    b_rd_en = 1; tick(); b_rd_en = 0;
    check("pack read empty", b_empty, 1);
    check("pack read rd_data", b_rd_data, 0);

    // Reset with 5 words stored plus 2 packed slices.
    b_wr_en = 1;
    for (int i = 0; i < 22; i++) begin
      b_wr_data = 8'(8'h60 + i);
      tick();
    end
    b_wr_en = 0;
    check("pre-rst b has_data", b_has, 1);
    rst = 1'b1; tick();
    check("mid-rst b full", b_full, 1);
    check("mid-rst b empty", b_empty, 1);
    rst = 1'b0; tick();
    check("after-rst b empty", b_empty, 1);
    check("after-rst b full", b_full, 0);
    b_wr_en = 1;
    for (int i = 1; i <= 4; i++) begin
      b_wr_data = 8'(i);
      tick();
    end
    b_wr_en = 0;
    tick();
    check("after-rst word has_data", b_has, 1);
    check("after-rst word rd_data", b_rd_data, 32'h04030201);
    b_rd_en = 1; tick(); b_rd_en = 0;
    check("after-rst drain empty", b_empty, 1);
    tick();
    check("after-rst no stale word", b_empty, 1);

`ifdef SYNC_FIFO_ASYMM_FLUSH_EN
    // Partial-word flush, then a flush with nothing packed.
    b_wr_en = 1;
    b_wr_data = 8'h11; tick();
    b_wr_data = 8'h22; tick();
    b_wr_en = 0; b_flush = 1; tick(); b_flush = 0;
    check("flush edge N has_data", b_has, 0);
    tick();
    check("flush has_data", b_has, 1);
    check("flush rd_data", b_rd_data, 32'h00002211);
    b_flush = 1; tick(); b_flush = 0; tick();
    check("empty flush keeps head", b_rd_data, 32'h00002211);
    b_rd_en = 1; tick(); b_rd_en = 0;
    check("empty flush no commit a", b_has, 0);
    tick();
    check("empty flush no commit b", b_has, 0);
    // Flush together with a write includes that slice.
    b_wr_en = 1;
    b_wr_data = 8'h33; tick();
    b_wr_data = 8'h44; b_flush = 1; tick();
    b_wr_en = 0; b_flush = 0; tick();
    check("flush+write rd_data", b_rd_data, 32'h00004433);
    b_rd_en = 1; tick(); b_rd_en = 0;
    check("flush+write drained", b_empty, 1);
`endif

    // 1:1 streaming through a one-word FIFO, pointers wrap past 16.
    c_wr_en = 1; c_wr_data = 8'h80; exp_q.push_back(8'h80); tick(); c_wr_en = 0;
    check("c first edge has_data", c_has, 0);
    tick();
    check("c first has_data", c_has, 1);
    check("c first rd_data", c_rd_data, 32'(exp_q[0]));
    for (int i = 0; i < 40; i++) begin
      c_wr_en = 1; c_rd_en = 1; c_wr_data = 8'(8'h81 + i);
      exp_q.push_back(c_wr_data);
      void'(exp_q.pop_front());
      tick();
      check($sformatf("stream%0d has_data", i), c_has, 1);
      check($sformatf("stream%0d rd_data", i), c_rd_data, 32'(exp_q[0]));
    end
    c_wr_en = 0; c_rd_en = 1;
    void'(exp_q.pop_front());
    tick();
    c_rd_en = 0;
    check("stream drained empty", c_empty, 1);
    check("stream scoreboard size", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_asymm_fwft.md
SYNC_FIFO_ASYMM_FWFT -- requirements
Module: sync_fifo_asymm_fwft

Interface
REQ-001 SHALL have parameter WR_WIDTH_BYTES, default 4, write port width in bytes.
REQ-002 SHALL have parameter RD_WIDTH_BYTES, default 1, read port width in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10; capacity is 2**ADDR_WIDTH storage words, each of width W = 8*max(WR_WIDTH_BYTES, RD_WIDTH_BYTES).
REQ-004 SHALL have parameter RESERVE, default 0, the number of storage words held back from full.
REQ-005 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have ports wr_en (input, 1, write strobe), wr_data (input, 8*WR_WIDTH_BYTES, write data) and full (output, 1, writes refused).
REQ-008 SHALL have ports rd_en (input, 1, read/advance strobe), rd_data (output, 8*RD_WIDTH_BYTES, FWFT head slice), empty (output, 1) and has_data (output, 1, always equal to ~empty).

Function
REQ-009 SHALL set R = max/min of the byte widths; R SHALL be a power of two from 1 to 16, with elaboration error otherwise.
REQ-010 SHALL run write-wider mode (WR>RD) as follows: each accepted write commits one storage word; the read side presents slice 0 (LSBs) first and pops the word after R accepted reads.
REQ-011 SHALL run read-wider mode (RD>WR) as follows: accepted writes pack slices LSB-first into a pack register; the R-th write commits the word and clears the pack count.
REQ-012 SHALL run equal mode (R=1) as plain FWFT FIFO pass-through.
REQ-013 SHALL accept a write only when wr_en=1 and full=0; wr_en while full is ignored, with no state change.
REQ-014 SHALL accept a read only when rd_en=1 and has_data=1; rd_en while empty is ignored.
REQ-015 SHALL, for FWFT, keep rd_data valid whenever has_data=1, unchanged until an accepted read.
REQ-016 SHALL, for first-word latency, assert has_data after edge N+1 when a commit is sampled at edge N on an empty FIFO.
REQ-017 SHALL assert full after the edge where the committed word count reaches 2**ADDR_WIDTH - RESERVE, and deassert it after the edge of the pop that drops the count below that.
REQ-018 SHALL, on a simultaneous accepted read and write, perform both; the count changes by commits minus pops.
REQ-019 SHALL wrap pointers modulo 2**ADDR_WIDTH without lost or duplicated words; slice counters SHALL wrap modulo R.
REQ-020 SHALL output bytes in write order across the width conversion, with no reordering.

Reset
REQ-021 SHALL, while rst=1, clear pointers, word count, read slice counter and pack count; pack register contents become don't-care.
REQ-022 SHALL hold outputs during and after reset at empty=1, has_data=0 and rd_data=0; full SHALL be 1 while rst=1 and 0 on the first cycle after.
REQ-023 SHALL discard all stored data and any partial pack on rst mid-operation; no word from before reset is ever read.

Configuration
REQ-024 SHALL, with macro SYNC_FIFO_ASYMM_FLUSH_EN defined, add input wr_flush (1 bit).
REQ-025 SHALL, in read-wider mode, treat wr_flush=1 with full=0 and pack count>0 as committing the partial word, with unfilled upper slices zero, and clear the pack count.
REQ-026 SHALL, on wr_flush together with an accepted wr_en, include that write's slice before committing; if this completes the word, commit once only.
REQ-027 SHALL ignore wr_flush when the pack count is 0, when full=1, or in write-wider or equal mode.
REQ-028 SHALL, without SYNC_FIFO_ASYMM_FLUSH_EN, omit the wr_flush port; a partial pack then remains held until completed by further writes or cleared by rst.

Verification
REQ-029 SHALL cover WR=4/RD=1: write 0x44332211, then read 4 consecutive cycles -> rd_data 0x11, 0x22, 0x33, 0x44, then empty=1.
REQ-030 SHALL cover WR=1/RD=4: write 0xA1, 0xB2, 0xC3 -> empty stays 1; write 0xD4 at edge N -> has_data=1 after N+1 with rd_data 0xD4C3B2A1.
REQ-031 SHALL cover ADDR_WIDTH=4, RESERVE=2: 14 writes -> full=1; 15th write ignored; one full pop -> full=0; the read stream matches the write stream.
REQ-032 SHALL cover a FIFO holding 1 word (WR=RD): simultaneous rd_en and wr_en each cycle for 40 cycles -> no gaps, has_data stays 1, pointers wrap past 16 correctly.
REQ-033 SHALL cover WR=1/RD=4 with FLUSH_EN: write 0x11, 0x22, then pulse wr_flush -> rd_data 0x00002211; a second flush with pack count 0 -> no commit.
REQ-034 SHALL cover assertion of rst for 1 cycle with 5 words stored plus 2 packed slices -> empty=1 and full=0 after reset; the next 4 writes produce a word made only of the new data.
